bit_serializer: RTL and testbench

Parallel-to-serial front end for the sequence detector. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `x`, which drives the detector's serial input directly. The detector samples `x` every clock and has no valid qualifier, so this block drives a defined idle bit whenever no word is being shifted.

---
 rtl/bit_serializer.sv | 95 +++++++++
 tb/tb_bit_serializer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: shifts WIDTH-bit words out one bit per clock on x, idle fill otherwise.
// Latency: first bit on x one edge after accept; a word occupies WIDTH consecutive cycles.
// Backpressure: din_ready is high in IDLE or on the last bit of a word, which allows gapless back-to-back words.
module bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             x_last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             accept;
    logic [WIDTH-1:0] shreg_shifted;
    logic             out_bit;

    // The output end of shreg depends on bit order; the vacated end fills with zero.
    always_comb begin
        shreg_shifted = '0;
        out_bit       = 1'b0;
        if (MSB_FIRST) begin
            shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
            out_bit       = shreg[WIDTH-1];
        end else begin
            shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
            out_bit       = shreg[0];
        end
    end

    // State, shift register and bit counter; reset discards any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Moore output decode plus next-state: outputs depend only on registered state.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        din_ready = (state == IDLE) || (cnt == '0);
        x_valid   = (state == SHIFT);
        x_last    = (state == SHIFT) && (cnt == '0);
        x         = (state == SHIFT) ? out_bit : IDLE_BIT;
        accept    = din_valid && din_ready;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    shreg_nxt = din;
                    cnt_nxt   = CNT_MAX;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt != '0) begin
                    shreg_nxt = shreg_shifted;
                    cnt_nxt   = cnt - 1'b1;
                end else if (accept) begin
                    // Reload on the last bit so the next word follows without an idle gap.
                    shreg_nxt = din;
                    cnt_nxt   = CNT_MAX;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share one stimulus stream.
// Expected bits are queued per accepted word and popped by a monitor on every falling edge.
// Accept timing is predicted from the queue occupancy, not read from the DUT.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;

    logic rdy0, x0, xv0, xl0;
    logic rdy1, x1, xv1, xl1;

    int checks = 0;
    int failures = 0;
    int acc_cnt = 0;
    bit exp_rdy = 1'b1;

    // Each entry: {last, bit}
    logic [1:0] q0[$];
    logic [1:0] q1[$];

    // Observed data bits per lane, shifted in from the right.
    logic [31:0] obs0 = '0;
    logic [31:0] obs1 = '0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(rdy0), .x(x0), .x_valid(xv0), .x_last(xl0)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(rdy1), .x(x1), .x_valid(xv1), .x_last(xl1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard push: an accept happens when valid is high and the model says the serializer is free.
    always @(posedge clk) begin
        if (rst_n && din_valid && exp_rdy) begin
            for (int i = 0; i < 8; i++) begin
                q0.push_back({(i == 7), din[7-i]});
                q1.push_back({(i == 7), din[i]});
            end
            acc_cnt++;
        end
    end

    // Reset drops every word in flight.
    always @(negedge rst_n) begin
        q0.delete();
        q1.delete();
        exp_rdy = 1'b1;
    end

    task automatic lane(input int l, input logic xa, input logic xva, input logic xla, input logic rdya);
        logic [1:0] e;
        bit         busy;
        int         left;
        e = 2'b00;
        if (l == 0) busy = (q0.size() != 0);
        else        busy = (q1.size() != 0);
        chk($sformatf("x_valid_l%0d", l), {31'd0, xva}, {31'd0, busy});
        if (busy) begin
            if (l == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("x_l%0d", l), {31'd0, xa}, {31'd0, e[0]});
            chk($sformatf("x_last_l%0d", l), {31'd0, xla}, {31'd0, e[1]});
        end else begin
            chk($sformatf("x_idle_l%0d", l), {31'd0, xa}, 32'd0);
            chk($sformatf("x_last_idle_l%0d", l), {31'd0, xla}, 32'd0);
        end
        if (l == 0) left = q0.size();
        else        left = q1.size();
        chk($sformatf("din_ready_l%0d", l), {31'd0, rdya}, {31'd0, (left == 0)});
    endtask

    // Monitor: compare every cycle while out of reset, then record the model's readiness for the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            lane(0, x0, xv0, xl0, rdy0);
            lane(1, x1, xv1, xl1, rdy1);
            if (xv0) obs0 = {obs0[30:0], x0};
            if (xv1) obs1 = {obs1[30:0], x1};
            exp_rdy = (q0.size() == 0);
        end
    end

    // Drive one word until the model records its accept; optionally keep valid high afterwards.
    task automatic send(input logic [7:0] w, input bit hold);
        int start;
        bit done;
        start = acc_cnt;
        done  = 1'b0;
        din = w;
        din_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (acc_cnt != start) done = 1'b1;
        end
        chk("send_accept_timeout", {31'd0, done}, 32'd1);
        if (!hold) din_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        din_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset hold
        repeat (3) @(negedge clk);
        chk("rst_x", {31'd0, x0}, 32'd0);
        chk("rst_x_valid", {31'd0, xv0}, 32'd0);
        chk("rst_x_last", {31'd0, xl0}, 32'd0);
        chk("rst_din_ready", {31'd0, rdy0}, 32'd1);
        chk("rst_x_lsb", {31'd0, x1}, 32'd0);
        #2 rst_n = 1'b1;

        // Idle for 10 cycles; monitor checks every cycle.
        idle_cycles(10);

        // Single word, one-cycle valid.
        obs0 = '0;
        send(8'hA5, 1'b0);
        idle_cycles(12);
        chk("single_A5_msb", obs0[7:0], 32'hA5);

        // Back-to-back with valid held high.
        obs0 = '0;
        send(8'hA5, 1'b1);
        send(8'h5A, 1'b0);
        idle_cycles(12);
        chk("b2b_msb", obs0[15:0], 32'hA55A);

        // LSB-first lane with 0x0D: bits 1,0,1,1,0,0,0,0.
        obs1 = '0;
        send(8'h0D, 1'b0);
        idle_cycles(12);
        chk("lsb_0D", obs1[7:0], 32'hB0);

        // Mid-word asynchronous reset after three bits of 0xFF.
        send(8'hFF, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_x", {31'd0, x0}, 32'd0);
        chk("midrst_x_valid", {31'd0, xv0}, 32'd0);
        chk("midrst_x_last", {31'd0, xl0}, 32'd0);
        chk("midrst_din_ready", {31'd0, rdy0}, 32'd1);
        chk("midrst_x_valid_lsb", {31'd0, xv1}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle_cycles(10);
        obs0 = '0;
        send(8'h80, 1'b0);
        idle_cycles(12);
        chk("post_rst_80", obs0[7:0], 32'h80);

        // Handshake stall: valid with changing data only while ready is low.
        obs0 = '0;
        send(8'hC3, 1'b0);
        for (int i = 0; i < 7; i++) begin
            din_valid = 1'b1;
            din = 8'($urandom);
            @(negedge clk);
        end
        send(8'h3C, 1'b0);
        idle_cycles(12);
        chk("stall_then_3C", obs0[15:0], 32'hC33C);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            din_valid = ($urandom_range(0, 3) != 0);
            din = 8'($urandom);
            @(negedge clk);
        end
        idle_cycles(12);
        chk("drain_q0", q0.size(), 32'd0);
        chk("drain_q1", q1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
